// File: rtl/loop_counter_nd.sv
// loop_counter_nd: chained nested-loop counter (level 0 innermost) with start/busy/done handshake
module loop_counter_nd #(
  parameter int CNT_WIDTH = 4,
  parameter int NUM_LVL   = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         start_i,
  input  logic                         en_i,
  input  logic                         clr_i,
  input  logic                         cont_i,
  input  logic [NUM_LVL*CNT_WIDTH-1:0] limit_i,
  output logic [NUM_LVL*CNT_WIDTH-1:0] cnt_o,
  output logic [NUM_LVL-1:0]           last_o,
  output logic                         busy_o,
  output logic                         done_o
);
  localparam int NW = NUM_LVL * CNT_WIDTH;
  typedef enum logic {IDLE, RUN} state_t;
  state_t          state_q, state_d;
  logic [NW-1:0]   cnt_q, cnt_d, lim_q, lim_d, cnt_inc;
  logic            cont_q, cont_d, done_q, done_d;
  logic [NUM_LVL:0]   carry;
  logic [NUM_LVL-1:0] at_lim;
  assign carry[0] = 1'b1;
  // a level moves only when every level below it sits at its limit
  for (genvar k = 0; k < NUM_LVL; k++) begin : g_lvl
    assign at_lim[k]   = cnt_q[k*CNT_WIDTH +: CNT_WIDTH] == lim_q[k*CNT_WIDTH +: CNT_WIDTH];
    assign carry[k+1]  = carry[k] & at_lim[k];
    assign cnt_inc[k*CNT_WIDTH +: CNT_WIDTH] = !carry[k] ? cnt_q[k*CNT_WIDTH +: CNT_WIDTH] :
                                               at_lim[k] ? '0 : cnt_q[k*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    cont_d  = cont_q;
    done_d  = 1'b0;
    if (clr_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE) begin
      if (start_i) begin
        state_d = RUN;
        cnt_d   = '0;
        lim_d   = limit_i;
        cont_d  = cont_i;
      end
    end else if (en_i) begin
      cnt_d = cnt_inc;
      if (carry[NUM_LVL]) begin
        done_d  = 1'b1;
        state_d = cont_q ? RUN : IDLE;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lim_q   <= '0;
      cont_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      cont_q  <= cont_d;
      done_q  <= done_d;
    end
  end
  assign busy_o = state_q == RUN;
  assign done_o = done_q;
  assign cnt_o  = cnt_q;
  assign last_o = at_lim & {NUM_LVL{busy_o}};
endmodule

// File: tb/tb_loop_counter_nd.sv
// tb_loop_counter_nd: scoreboard bench; reference model tracks a linear step index decoded as mixed-radix digits
module tb_loop_counter_nd;
  localparam int W  = 4;
  localparam int N  = 2;
  localparam int NW = W * N;
  typedef struct packed {
    logic [NW-1:0] cnt;
    logic [N-1:0]  last;
    logic          busy;
    logic          done;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, en = 1'b0, clr = 1'b0, cont = 1'b0;
  logic [NW-1:0] limit = '0, cnt;
  logic [N-1:0]  last;
  logic          busy, done;
  int compared = 0, mismatched = 0;
  int m_lim[N];
  int m_idx = 0;
  bit m_busy = 0, m_cont = 0;
  exp_t q[$];
  loop_counter_nd #(.CNT_WIDTH(W), .NUM_LVL(N)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .en_i(en), .clr_i(clr),
    .cont_i(cont), .limit_i(limit), .cnt_o(cnt), .last_o(last), .busy_o(busy), .done_o(done)
  );
  always #5 clk = ~clk;
  function automatic int total();
    int p = 1;
    for (int k = 0; k < N; k++) p *= m_lim[k] + 1;
    return p;
  endfunction
  function automatic exp_t expect_now(bit d);
    exp_t e;
    int r = m_idx;
    e = '0;
    for (int k = 0; k < N; k++) begin
      int dig = r % (m_lim[k] + 1);
      r = r / (m_lim[k] + 1);
      e.cnt[k*W +: W] = W'(dig);
      e.last[k] = m_busy && dig == m_lim[k];
    end
    e.busy = m_busy;
    e.done = d;
    return e;
  endfunction
  task automatic drive(input bit s, input bit e, input bit c, input bit md, input logic [NW-1:0] lim);
    bit d;
    d = 0;
    @(negedge clk);
    start = s; en = e; clr = c; cont = md; limit = lim;
    if (c) begin
      m_busy = 0; m_idx = 0;
    end else if (!m_busy && s) begin
      for (int k = 0; k < N; k++) m_lim[k] = int'(lim[k*W +: W]);
      m_cont = md; m_idx = 0; m_busy = 1;
    end else if (m_busy && e) begin
      m_idx++;
      if (m_idx == total()) begin
        m_idx = 0; d = 1;
        if (!m_cont) m_busy = 0;
      end
    end
    q.push_back(expect_now(d));
  endtask
  task automatic model_reset();
    for (int k = 0; k < N; k++) m_lim[k] = 0;
    m_idx = 0; m_busy = 0; m_cont = 0;
  endtask
  task automatic check_zero(input string name);
    compared++;
    if ({cnt, last, busy, done} !== '0) begin
      mismatched++;
      $display("FAIL %s: got cnt=%h last=%b busy=%b done=%b, want all zero", name, cnt, last, busy, done);
    end
  endtask
  initial begin
    exp_t e, g;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        g = '{cnt: cnt, last: last, busy: busy, done: done};
        compared++;
        if (g !== e) begin
          mismatched++;
          $display("FAIL outputs @%0t: got cnt=%h last=%b busy=%b done=%b, want cnt=%h last=%b busy=%b done=%b",
                   $time, g.cnt, g.last, g.busy, g.done, e.cnt, e.last, e.busy, e.done);
        end
      end
    end
  end
  initial begin
    int guard;
    model_reset();
    #2 rst_n = 1'b0;
    #10 check_zero("reset_state");
    @(negedge clk) rst_n = 1'b1;
    repeat (3) drive(0, 1, 0, 0, 8'h23);
    // full pass, en held high, one-shot
    drive(1, 1, 0, 0, 8'h23);
    repeat (14) drive(0, 1, 0, 0, 8'h00);
    // random stalls
    drive(1, 0, 0, 0, 8'h23);
    guard = 0;
    while (m_busy && guard < 200) begin
      drive(0, 1'($urandom % 2), 0, 0, 8'h00);
      guard++;
    end
    compared++;
    if (m_busy) begin
      mismatched++;
      $display("FAIL stall_run: model still busy after %0d cycles, want done", guard);
    end
    // continuous mode
    drive(1, 0, 0, 1, 8'h11);
    repeat (12) drive(0, 1, 0, 0, 8'h00);
    drive(0, 0, 1, 0, 8'h00);
    // single-state levels
    drive(1, 0, 0, 0, 8'h05);
    repeat (7) drive(0, 1, 0, 0, 8'h00);
    drive(1, 0, 0, 0, 8'h30);
    repeat (5) drive(0, 1, 0, 0, 8'h00);
    // start ignored mid-run
    drive(1, 0, 0, 0, 8'h23);
    repeat (6) drive(0, 1, 0, 0, 8'h00);
    drive(1, 1, 0, 0, 8'h11);
    repeat (7) drive(0, 1, 0, 0, 8'h00);
    // clear mid-run, then clear on the final step
    drive(1, 0, 0, 0, 8'h23);
    repeat (6) drive(0, 1, 0, 0, 8'h00);
    drive(0, 1, 1, 0, 8'h00);
    drive(0, 1, 0, 0, 8'h00);
    drive(1, 0, 0, 0, 8'h23);
    repeat (11) drive(0, 1, 0, 0, 8'h00);
    drive(0, 1, 1, 0, 8'h00);
    repeat (2) drive(0, 1, 0, 0, 8'h00);
    // randomized control mix
    for (int i = 0; i < 400; i++)
      drive(1'($urandom % 6 == 0), 1'($urandom % 3 != 0), 1'($urandom % 60 == 0), 1'($urandom % 2),
            {4'($urandom_range(0, 3)), 4'($urandom_range(0, 4))});
    // async reset between edges
    drive(1, 0, 0, 0, 8'h23);
    repeat (5) drive(0, 1, 0, 0, 8'h00);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    repeat (4) drive(0, 1, 0, 0, 8'h00);
    repeat (3) @(posedge clk);
    #2;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/loop_counter_nd.md
Name: loop_counter_nd

Overview:
- Parametrised nested-loop counter for the fitness-evaluation datapath.
- Chains NUM_LVL counter levels, each CNT_WIDTH bits wide, with a per-level programmable limit. Level 0 is the innermost level, for example the gene index; higher levels cover individual and generation.
- A start/busy/done handshake is added on top, plus a one-shot or continuous mode. Sequencers use this in place of hand-cascaded simple counters.

Parameters:
- CNT_WIDTH, 4: width of each level counter.
- NUM_LVL, 2: number of chained levels, minimum 1.

Ports:
- clk_i  input  1  clock. All flops on the rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- start_i  input  1  start a sequence. Honoured only in IDLE.
- en_i  input  1  advance by one step. Honoured only in RUN.
- clr_i  input  1  synchronous abort back to IDLE.
- cont_i  input  1  mode: 1 = wrap and keep running, 0 = stop after the last step. Sampled at start.
- limit_i  input  NUM_LVL*CNT_WIDTH  per-level terminal values. Level k occupies bits [k*CNT_WIDTH +: CNT_WIDTH]. Sampled at start.
- cnt_o  output  NUM_LVL*CNT_WIDTH  registered level counts, same packing as limit_i.
- last_o  output  NUM_LVL  bit k = 1 when level k equals its latched limit and busy_o = 1.
- busy_o  output  1  registered; 1 in RUN.
- done_o  output  1  registered one-cycle pulse when the full sequence completes.

Behaviour:
- Reset: state IDLE. cnt_o = 0, busy_o = 0, done_o = 0, latched limits = 0, latched mode = 0. last_o = 0.
- Priority per edge: rst_n_i > clr_i > start_i > en_i.
- FSM has two states, IDLE and RUN.
- IDLE + start_i:
  - latch limit_i and cont_i; set cnt_o = 0.
  - busy_o = 1 from the next cycle.
  - en_i in the same cycle as start_i is ignored.
- IDLE without start_i: en_i has no effect and cnt_o holds.
- RUN + en_i = 0: all registers hold. Stalls are unlimited.
- RUN + en_i = 1, increment rule:
  - Level 0 increments. If level k equals its limit, it wraps to 0 and carries into level k+1.
  - Level k changes only when all levels below k are at their limits.
  - Limit value L gives L+1 states per level. L = 0 means the level wraps on every carry in.
  - Counters never exceed their limit. Full-scale limit (2^CNT_WIDTH − 1) wraps naturally.
- Final step: en_i accepted while every level is at its limit (all last_o = 1). Then all levels go to 0 and done_o = 1 on the next cycle for exactly one cycle.
  - Latched cont = 0: state goes to IDLE, so busy_o = 0 in the same cycle that done_o = 1.
  - Latched cont = 1: stay in RUN, continue from all-zero, and pulse done_o again every full pass.
- Total steps per pass = product of (limit_k + 1).
- start_i during RUN is ignored. Limits and mode do not change mid-run.
- clr_i in any state:
  - cnt_o = 0, state IDLE, busy_o = 0 next cycle.
  - done_o is not asserted, including when clr_i coincides with the final step.
  - Latched limits are retained but unused.
- last_o is combinational from cnt_o and the latched limits, gated by busy_o. Its purpose is to let downstream logic flag the end of an inner loop one step early.
- rst_n_i asserted mid-run: immediate return to reset values, with no done_o.
- Width: no arithmetic overflow beyond CNT_WIDTH. The comparison is equality only.

Test Plan:
- NUM_LVL=2, CNT_WIDTH=4, limit={L1=2, L0=3}, cont=0, start, then en_i held high:
  - cnt_o(L1,L0) steps (0,0),(0,1)…(0,3),(1,0)…(2,3),(0,0).
  - done_o pulses once on the cycle after the 12th en_i, and busy_o drops in that cycle.
  - last_o[0] = 1 at L0 = 3; last_o[1] = 1 at L1 = 2.
- Same config, en_i toggled randomly ~50%:
  - cnt_o advances only on en_i = 1 cycles.
  - done_o appears after exactly 12 accepted enables.
- cont=1, limit={1,1}, en_i high for 12 cycles:
  - done_o pulses on cycles 4, 8 and 12 after the first en_i.
  - busy_o stays 1 throughout and cnt_o restarts at (0,0).
- Limit={0,5}: level 1 stays 0 and done_o follows the 6th en_i. Then limit={3,0}: level 0 stays 0, level 1 steps on every en_i, and done_o follows the 4th en_i.
- Mid-run control, at count (1,2):
  - start_i with new limits has no effect; the sequence completes with the old limits.
  - A second run then gets clr_i at (1,2): cnt_o = 0, busy_o = 0, no done_o.
  - clr_i together with the final en_i: no done_o.
- rst_n_i pulsed low asynchronously mid-run, between clock edges:
  - all outputs return to 0 immediately.
  - en_i after release has no effect until start_i.
